instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control sequencer for the 4-bit processor core. It fetches 16-bit instructions from program memory over a req/ack handshake and steps each one through DECODE, EXEC, optional MEM and WB. While it does so, it drives the register-file address fields, the ALU opcode, the data-memory handshake and a single-cycle register write strobe. It sits between the program memory and the existing control unit / register file / ALU / data memory, and replaces free-running per-clock operation with ordered instruction execution.

## Interface
- PC_W, 4, program counter width; program space is 2^PC_W instructions
- CNT_W, 8, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution from pc=0; sampled only in IDLE or HALT
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (equals pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction: opcode[15:12], rd[11:8], rs1[7:4], rs2/addr[3:0]
- opcode  out  4  latched opcode to control unit / ALU
- read_reg1, read_reg2, write_reg  out  4 each  latched rs1, rs2, rd fields
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_addr  out  4  latched addr field
- dmem_ack  in  1  data access complete
- reg_write  out  1  one-cycle register-file write strobe
- wb_sel_mem  out  1  1 = write-back from memory, 0 = from ALU; valid with reg_write
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- pc  out  PC_W  program counter
- retired  out  CNT_W  count of completed instructions

## Operation
- Instruction classes by opcode:
  - 4'hF = HALT
  - 4'hE = LOAD (rd <= mem[addr])
  - 4'hD = STORE (mem[addr] <= rs1)
  - 4'hC = JMP (pc <= zero-extended addr)
  - all others = ALU op (rd <= rs1 op rs2)
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: on start, pc <= 0 and go to FETCH.
- FETCH: imem_req held high until imem_ack. On ack, latch the instruction and set pc <= pc+1 (mod 2^PC_W, wraps 2^PC_W-1 -> 0). Go to DECODE.
- DECODE (1 cycle): opcode and register fields are valid on their outputs.
  - HALT goes to HALT; retired is incremented.
  - All other classes go to EXEC.
- EXEC (1 cycle):
  - JMP: pc <= addr, retired++, go to FETCH.
  - LOAD/STORE: go to MEM.
  - ALU: go to WB.
- MEM: dmem_req held high, with dmem_we=1 for STORE and 0 for LOAD, until dmem_ack.
  - STORE: on ack, retired++ and go to FETCH.
  - LOAD: on ack, go to WB.
- WB (1 cycle): reg_write=1 with wb_sel_mem=1 for LOAD, 0 for ALU. retired++, go to FETCH.
- HALT: start restarts with pc <= 0 and goes to FETCH. retired is not cleared.
- retired wraps modulo 2^CNT_W.
- Handshake rules:
  - req stays asserted with stable addr/we until ack.
  - ack while the matching req is low is ignored.
  - req drops in the cycle after the ack cycle.
- start outside IDLE/HALT is ignored.
- Reset, including mid-transfer, takes effect immediately. All outputs go to 0 and state goes to IDLE. An outstanding request is abandoned, and a late ack after reset is ignored.

## Timing
- Reset values:
  - pc, retired, opcode, all register fields and dmem_addr = 0
  - imem_req, dmem_req, dmem_we, reg_write, wb_sel_mem, busy, halted = 0
- All outputs are registered.
- Cycle counts, with ack given in the first req cycle (zero-wait):
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB)
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - JMP: 3 cycles
  - HALT: 2 cycles to HALT
- Each wait cycle on imem_ack or dmem_ack adds exactly one cycle.
- The first imem_req rises the cycle after start is sampled.
- reg_write is high for exactly one cycle per ALU/LOAD instruction and never otherwise.
- halted rises in the cycle after DECODE of HALT. busy falls in the same cycle.

## Test plan
- Reset, then start, with program `ALU 0x1123` at pc 0 and zero-wait acks. Required response:
  - imem_req is high 1 cycle.
  - reg_write pulses 4 cycles after start with write_reg=1, read_reg1=2, read_reg2=3, wb_sel_mem=0.
  - pc=1 and retired=1.
- LOAD 0xE205 with dmem_ack delayed 3 cycles. Required response:
  - dmem_req is high 4 cycles with dmem_we=0 and dmem_addr=5.
  - reg_write is then asserted with wb_sel_mem=1 and write_reg=2.
  - Total instruction time is 8 cycles.
- STORE 0xD070 followed by HALT 0xF000. Required response:
  - dmem_we=1 with dmem_addr=0.
  - No reg_write occurs.
  - halted rises with retired=2 and pc=2.
  - A later start restarts fetch at pc=0.
- PC_W=4 program: JMP 0xC00F at pc 0, then an ALU op at pc 15. Required response:
  - After the ALU op, pc wraps to 0.
  - imem_addr sequence is 0, 15, 0.
- Assert rst while imem_req is waiting with no ack, then deliver a late imem_ack. Required response:
  - All outputs are 0 and state is IDLE.
  - The late ack is ignored.
  - start, held high while busy, has no effect until HALT/IDLE.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit instructions over a
// req/ack handshake and steps each one through DECODE, EXEC, optional MEM
// and WB, driving register-file fields, ALU opcode and data-memory handshake.
module instr_sequencer #(
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  output logic [3:0]       opcode,
  output logic [3:0]       read_reg1,
  output logic [3:0]       read_reg2,
  output logic [3:0]       write_reg,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [3:0]       dmem_addr,
  input  logic             dmem_ack,
  output logic             reg_write,
  output logic             wb_sel_mem,
  output logic             busy,
  output logic             halted,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] OP_LOAD  = 4'hE;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_JMP   = 4'hC;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [15:0]      ir_q, ir_d;

  // Control outputs are flopped from the next state so they line up
  // exactly with the state they describe.
  logic imem_req_q, imem_req_d;
  logic dmem_req_q, dmem_req_d;
  logic dmem_we_q, dmem_we_d;
  logic reg_write_q, reg_write_d;
  logic wb_sel_q, wb_sel_d;
  logic busy_q, busy_d;
  logic halted_q, halted_d;

  logic [3:0] op_q;
  assign op_q = ir_q[15:12];

  // State, datapath and output registers; reset abandons any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ret_q       <= '0;
      ir_q        <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ret_q       <= ret_d;
      ir_q        <= ir_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state: instruction stepping, pc update and retire counting.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OP_HALT) begin
          ret_d   = ret_q + CNT_W'(1);
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_JMP) begin
          pc_d    = PC_W'(ir_q[3:0]);
          ret_d   = ret_q + CNT_W'(1);
          state_d = S_FETCH;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op_q == OP_STORE) begin
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        ret_d   = ret_q + CNT_W'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered above.
  always_comb begin
    imem_req_d  = (state_d == S_FETCH);
    dmem_req_d  = (state_d == S_MEM);
    dmem_we_d   = (state_d == S_MEM) && (ir_d[15:12] == OP_STORE);
    reg_write_d = (state_d == S_WB);
    wb_sel_d    = (state_d == S_WB) && (ir_d[15:12] == OP_LOAD);
    busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d    = (state_d == S_HALT);
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign retired    = ret_q;
  assign opcode     = ir_q[15:12];
  assign write_reg  = ir_q[11:8];
  assign read_reg1  = ir_q[7:4];
  assign read_reg2  = ir_q[3:0];
  assign dmem_addr  = ir_q[3:0];
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign reg_write  = reg_write_q;
  assign wb_sel_mem = wb_sel_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model predicts fetch
// addresses, per-instruction cycle counts, write-backs and memory accesses.
module tb_instr_sequencer;
  localparam int PC_W  = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic imem_req, dmem_req, dmem_we, reg_write, wb_sel_mem, busy, halted;
  logic [PC_W-1:0] imem_addr, pc;
  logic [CNT_W-1:0] retired;
  logic [3:0] opcode, read_reg1, read_reg2, write_reg, dmem_addr;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode(opcode), .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .reg_write(reg_write), .wb_sel_mem(wb_sel_mem), .busy(busy), .halted(halted),
    .pc(pc), .retired(retired)
  );

  int checks = 0, failures = 0;
  logic [15:0] prog [16];
  int cyc = 0;

  // instruction-level model state
  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_ret;
  bit m_running, exp_wr, exp_sel, exp_mem, exp_we, exp_halt;
  logic [3:0] exp_rd, exp_rs1, exp_rs2, exp_addr;
  int exp_dur, inst_start;
  bit inst_active, pend_start, prev_req, prev_halted;
  int iw_left, iw_used, dw_left, dw_used, icnt, dcnt;
  int iw_fix = 0, dw_fix = 0;
  bit noise = 0, hold_start = 0, start_pulse = 0;
  int halt_cnt = 0, start_cyc = 0, rw_cyc = 0;
  logic [PC_W-1:0] addrs [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_ret = '0; m_running = 0;
    exp_wr = 0; exp_mem = 0; exp_halt = 0; inst_active = 0; pend_start = 0;
    prev_req = 0; prev_halted = 0; icnt = 0; dcnt = 0; iw_left = 0; dw_left = 0;
    addrs.delete();
  endtask

  // Architectural effect and expected timing of one fetched instruction.
  task automatic exec_model(input logic [15:0] ins);
    logic [3:0] op;
    op = ins[15:12];
    exp_rd = ins[11:8]; exp_rs1 = ins[7:4]; exp_rs2 = ins[3:0]; exp_addr = ins[3:0];
    dw_used = (dw_fix >= 0) ? dw_fix : int'($urandom_range(0, 3));
    dw_left = dw_used; dcnt = 0;
    m_pc = m_pc + 4'd1;
    m_ret = m_ret + 8'd1;
    case (op)
      4'hF: begin exp_halt = 1; exp_dur = 2 + iw_used; end
      4'hE: begin exp_mem = 1; exp_we = 0; exp_wr = 1; exp_sel = 1; exp_dur = 5 + iw_used + dw_used; end
      4'hD: begin exp_mem = 1; exp_we = 1; exp_dur = 4 + iw_used + dw_used; end
      4'hC: begin m_pc = ins[3:0]; exp_dur = 3 + iw_used; end
      default: begin exp_wr = 1; exp_sel = 0; exp_dur = 4 + iw_used; end
    endcase
  endtask

  // Observe this cycle's outputs, then drive inputs for the next edge.
  task automatic sample();
    if (pend_start) begin chk("first_req", imem_req, 1); pend_start = 0; end
    if (imem_req && !prev_req) begin
      if (inst_active) begin
        chk("inst_cycles", cyc - inst_start, exp_dur);
        chk("wr_missing", exp_wr, 0);
        chk("mem_missing", exp_mem, 0);
      end
      chk("fetch_addr", imem_addr, m_pc);
      chk("retired", retired, m_ret);
      chk("busy_run", busy, 1);
      addrs.push_back(imem_addr);
      inst_active = 1; inst_start = cyc; icnt = 0;
      iw_used = (iw_fix >= 0) ? iw_fix : int'($urandom_range(0, 3));
      iw_left = iw_used;
    end
    if (halted && !prev_halted) begin
      chk("halt_expected", exp_halt, 1);
      chk("halt_cycles", cyc - inst_start, exp_dur);
      chk("halt_retired", retired, m_ret);
      chk("halt_pc", pc, m_pc);
      chk("halt_busy", busy, 0);
      exp_halt = 0; inst_active = 0; m_running = 0; halt_cnt++;
    end
    if (reg_write) begin
      chk("rw_expected", exp_wr, 1);
      chk("wb_sel", wb_sel_mem, exp_sel);
      chk("write_reg", write_reg, exp_rd);
      if (!exp_sel) begin
        chk("alu_rs1", read_reg1, exp_rs1);
        chk("alu_rs2", read_reg2, exp_rs2);
      end
      exp_wr = 0; rw_cyc = cyc;
    end
    if (dmem_req) begin
      chk("dmem_expected", exp_mem, 1);
      chk("dmem_we", dmem_we, exp_we);
      chk("dmem_addr", dmem_addr, exp_addr);
      if (exp_we) chk("store_src", read_reg1, exp_rs1);
      dcnt++;
    end
    if (imem_req) begin chk("imem_addr_hold", imem_addr, m_pc); icnt++; end

    imem_ack = 0; dmem_ack = 0; start = 0;
    if (imem_req) begin
      if (iw_left == 0) begin
        chk("imem_req_cycles", icnt, iw_used + 1);
        imem_ack = 1; imem_rdata = prog[imem_addr];
        exec_model(prog[m_pc]);
      end else begin
        iw_left--; imem_rdata = 16'($urandom);
      end
    end else if (noise) imem_ack = ($urandom_range(0, 3) == 0);
    if (dmem_req) begin
      if (dw_left == 0) begin
        chk("dmem_req_cycles", dcnt, dw_used + 1);
        dmem_ack = 1; exp_mem = 0;
      end else dw_left--;
    end else if (noise) dmem_ack = ($urandom_range(0, 3) == 0);
    if (hold_start || start_pulse) start = 1;
    start_pulse = 0;
    if (start && !m_running) begin
      m_running = 1; m_pc = '0; pend_start = 1; start_cyc = cyc;
    end
    prev_req = imem_req; prev_halted = halted;
  endtask

  task automatic sample_cycle();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic run_n(input int n);
    repeat (n) sample_cycle();
  endtask

  task automatic wait_halt(input int budget);
    int h0, n;
    h0 = halt_cnt; n = 0;
    while (halt_cnt == h0 && n < budget) begin sample_cycle(); n++; end
    chk("halt_reached", (halt_cnt != h0), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; imem_ack = 0; dmem_ack = 0; start = 0;
    #1;
    chk("rst_ctrl", {imem_req, dmem_req, dmem_we, reg_write, wb_sel_mem, busy, halted}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_retired", retired, 0);
    chk("rst_fields", {opcode, read_reg1, read_reg2, write_reg, dmem_addr}, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
    model_reset();
    rst = 1;
    #1;
    chk("por_busy", busy, 0);

    // ALU op then HALT, zero-wait
    do_reset();
    prog[0] = 16'h1123; prog[1] = 16'hF000;
    start_pulse = 1;
    wait_halt(40);
    chk("t1_rw_latency", rw_cyc - start_cyc, 4);

    // LOAD with dmem_ack delayed three cycles
    do_reset();
    prog[0] = 16'hE205; prog[1] = 16'hF000;
    dw_fix = 3;
    start_pulse = 1;
    wait_halt(40);
    dw_fix = 0;

    // STORE then HALT, then restart from pc 0
    do_reset();
    prog[0] = 16'hD070; prog[1] = 16'hF000;
    start_pulse = 1;
    wait_halt(40);
    chk("t3_retired", retired, 2);
    chk("t3_pc", pc, 2);
    run_n(3);
    chk("t3_stay_halted", halted, 1);
    start_pulse = 1;
    wait_halt(40);
    chk("t3_retired_kept", retired, 4);

    // JMP to 15, ALU at 15, pc wraps to 0; reset while that fetch waits
    do_reset();
    prog[0] = 16'hC00F; prog[15] = 16'h1456; prog[1] = 16'hF000;
    start_pulse = 1;
    n = 0;
    while (addrs.size() < 2 && n < 50) begin sample_cycle(); n++; end
    iw_fix = 1000;
    while (addrs.size() < 3 && n < 100) begin sample_cycle(); n++; end
    chk("t4_fetch_count", addrs.size(), 3);
    if (addrs.size() >= 3) begin
      chk("t4_addr0", addrs[0], 0);
      chk("t4_addr1", addrs[1], 15);
      chk("t4_addr2", addrs[2], 0);
    end
    run_n(3);
    chk("t4_still_waiting", imem_req, 1);
    do_reset();
    imem_ack = 1; imem_rdata = 16'h1123;
    @(negedge clk);
    imem_ack = 0;
    chk("late_ack_req", imem_req, 0);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_opcode", opcode, 0);
    chk("late_ack_pc", pc, 0);
    iw_fix = 0;

    // start held high through execution: only honoured in IDLE/HALT
    do_reset();
    prog[0] = 16'h1123; prog[1] = 16'hE205; prog[2] = 16'hF000;
    iw_fix = 1; dw_fix = 2;
    hold_start = 1;
    wait_halt(60);
    hold_start = 0;
    wait_halt(60);
    chk("t5_retired", retired, 6);

    // randomized programs, waits and stray acks
    noise = 1; iw_fix = -1; dw_fix = -1;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
      hold_start = 1;
      run_n((r == 2) ? 2000 : 500);
      hold_start = 0;
    end
    noise = 0;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
